// File: rtl/conv_sequencer.sv
// conv_sequencer: two-pass separable blur sequencer around a row-convolution engine.
//
// A start in IDLE with both dimensions >= 6 latches the image size and kernel select,
// then runs the engine twice. Pass 1 reads the image SRAM and writes the buffer SRAM
// transposed. Pass 2 reads the buffer back with swapped dimensions and writes it
// transposed again, so the result lands untransposed in the image SRAM. Each pass holds
// the engine in reset for RST_HOLD cycles, then waits for a busy high-then-low handshake
// under a watchdog.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               one-cycle request, honoured only in IDLE
//   nrows, ncols, sigma image dimensions and kernel select for the request
//   busy, done, err     sequence active, one-cycle completion pulse, sticky error
//   eng_rstn            active-low engine hold, high only while a pass runs
//   eng_nrows/ncols     per-pass engine dimensions
//   eng_sigma           engine kernel select
//   eng_transpose       engine transposes on write
//   eng_busy            engine busy input
//   src_sel             0: image SRAM -> buffer SRAM, 1: buffer SRAM -> image SRAM
//   host_req, host_gnt  host SRAM ownership request / grant (grant only in IDLE)
//   state               current FSM state for debug
module conv_sequencer #(
    parameter int unsigned RST_HOLD = 2,
    parameter logic [19:0] WDOG_CYC = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] nrows,
    input  logic [7:0] ncols,
    input  logic [2:0] sigma,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       eng_rstn,
    output logic [7:0] eng_nrows,
    output logic [7:0] eng_ncols,
    output logic [2:0] eng_sigma,
    output logic       eng_transpose,
    input  logic       eng_busy,
    output logic       src_sel,
    input  logic       host_req,
    output logic       host_gnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArm1 = 3'd1,
        StRun1 = 3'd2,
        StArm2 = 3'd3,
        StRun2 = 3'd4,
        StDone = 3'd5,
        StErr  = 3'd6
    } state_e;

    localparam int unsigned HoldW = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned HoldLastInt = (RST_HOLD > 0) ? RST_HOLD - 1 : 0;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldLastInt);

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q;
    logic [19:0]        wdog_q;
    logic               seen_busy_q;

    logic dims_ok, accept, in_arm, in_run, hold_last, wdog_expire, pass_done;

    assign dims_ok     = (nrows >= 8'd6) && (ncols >= 8'd6);
    assign accept      = (state_q == StIdle) && start && dims_ok;
    assign in_arm      = (state_q == StArm1) || (state_q == StArm2);
    assign in_run      = (state_q == StRun1) || (state_q == StRun2);
    assign hold_last   = (hold_q == HoldLast);
    // Expire on the cycle whose increment would bring the count up to the limit.
    assign wdog_expire = ({1'b0, wdog_q} + 21'd1) >= {1'b0, WDOG_CYC};
    // The engine must be seen busy at least once before a low busy means finished.
    assign pass_done   = seen_busy_q && !eng_busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = dims_ok ? StArm1 : StErr;
                end
            end
            StArm1: if (hold_last) state_d = StRun1;
            StRun1: begin
                if (pass_done) begin
                    state_d = StArm2;
                end else if (wdog_expire) begin
                    state_d = StErr;
                end
            end
            StArm2: if (hold_last) state_d = StRun2;
            StRun2: begin
                if (pass_done) begin
                    state_d = StDone;
                end else if (wdog_expire) begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they switch on the same edge as state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            wdog_q        <= '0;
            seen_busy_q   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            eng_rstn      <= 1'b0;
            eng_nrows     <= '0;
            eng_ncols     <= '0;
            eng_sigma     <= '0;
            eng_transpose <= 1'b0;
            src_sel       <= 1'b0;
            host_gnt      <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy     <= (state_d == StArm1) || (state_d == StRun1) || (state_d == StArm2) ||
                        (state_d == StRun2) || (state_d == StDone);
            done     <= (state_d == StDone);
            eng_rstn <= (state_d == StRun1) || (state_d == StRun2);
            host_gnt <= (state_d == StIdle) && host_req;

            if (state_d == StErr) begin
                err <= 1'b1;
            end else if (accept) begin
                err <= 1'b0;
            end

            if (accept) begin
                eng_nrows     <= nrows;
                eng_ncols     <= ncols;
                eng_sigma     <= sigma;
                eng_transpose <= 1'b1;
                src_sel       <= 1'b0;
            end else if ((state_q == StRun1) && (state_d == StArm2)) begin
                // Second pass walks the transposed buffer, so the dimensions swap.
                eng_nrows <= eng_ncols;
                eng_ncols <= eng_nrows;
                src_sel   <= 1'b1;
            end

            if (state_d != state_q) begin
                hold_q <= '0;
            end else if (in_arm) begin
                hold_q <= hold_q + 1'b1;
            end

            if (state_d != state_q) begin
                wdog_q <= '0;
            end else if (in_run) begin
                wdog_q <= wdog_q + 20'd1;
            end

            if ((state_d == StArm1) || (state_d == StArm2)) begin
                seen_busy_q <= 1'b0;
            end else if (in_run && eng_busy) begin
                seen_busy_q <= 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule
